// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the nibble-serial add/subtract sequencer
package serial_adder_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: W-bit ripple-carry adder shared across operand nibbles
module ripple_carry_adder #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);
   logic [W:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[W];
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: steps one 4-bit adder across WIDTH-bit operands, LSB nibble first
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             busy_o
);
   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);
   state_t state_q, state_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, sum_q;
   logic [IDX_W-1:0] idx_q;
   logic carry_q, cout_q, ovf_q, rdy_q;
   logic [NIBBLE_W-1:0] add_sum;
   logic add_cout, accept, last;
   assign accept = req_valid_i && rdy_q;
   assign last = idx_q == LAST;
   ripple_carry_adder #(.W(NIBBLE_W)) u_rca (
      .a(a_q[idx_q]),
      .b(b_q[idx_q]),
      .cin(carry_q),
      .sum(add_sum),
      .cout(add_cout)
   );
   // state register; reset overrides any handshake
   always_ff @(posedge clk_i)
      state_q <= rst_i ? IDLE : state_d;
   // next state: accept in IDLE, finish after the last nibble, release on response handshake
   always_comb begin
      state_d = state_q;
      state_d = state_q == IDLE ? (accept ? RUN : IDLE) :
                state_q == RUN  ? (last ? DONE : RUN) :
                                  (rsp_ready_i ? IDLE : DONE);
   end
   // operand capture, per-nibble accumulation and registered ready
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdy_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         rdy_q <= state_d == IDLE;
         if (accept) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            idx_q   <= '0;
         end else if (state_q == RUN) begin
            sum_q[idx_q] <= add_sum;
            carry_q      <= add_cout;
            idx_q        <= last ? idx_q : idx_q + 1'b1;
            if (last) begin
               cout_q <= add_cout;
               ovf_q  <= (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                         (add_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
            end
         end
      end
   end
   assign req_ready_o = rdy_q;
   assign rsp_valid_o = state_q == DONE;
   assign busy_o      = state_q != IDLE;
   assign sum_o       = sum_q;
   assign cout_o      = cout_q;
   assign ovf_o       = ovf_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Multi-precision add/subtract sequencer. It computes a WIDTH-bit sum or difference by stepping one shared 4-bit `ripple_carry_adder` across the operands, one nibble per cycle, LSB first, holding the carry in a register between steps. Requests and responses use valid/ready handshakes. The block sits between a requesting master and the 4-bit adder datapath, trading latency for adder area.

## Interface

Parameters:
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 4.
- `NIBBLES`, derived as WIDTH/4: number of adder steps per operation.

Ports:
- `clk_i`, input, 1: clock. The block uses this single clock.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: block can accept a request.
- `a_i`, input, WIDTH: operand A.
- `b_i`, input, WIDTH: operand B.
- `cin_i`, input, 1: carry-in. Ignored when `sub_i`=1.
- `sub_i`, input, 1: 0 selects A+B+cin; 1 selects A−B.
- `rsp_valid_o`, output, 1: result valid.
- `rsp_ready_i`, input, 1: consumer accepts the result.
- `sum_o`, output, WIDTH: result.
- `cout_o`, output, 1: carry out of the MSB. For subtract, 1 means no borrow.
- `ovf_o`, output, 1: two's-complement signed overflow.
- `busy_o`, output, 1: high in RUN or DONE.

## Operation

FSM with three states:
- IDLE → RUN on `req_valid_i && req_ready_o`.
- RUN → DONE after NIBBLES steps.
- DONE → IDLE on `rsp_ready_i`.

Behaviour in each state:
- **IDLE:** `req_ready_o`=1.
  - On handshake, capture `a_q`=`a_i` and `b_q`=(`sub_i` ? ~`b_i` : `b_i`).
  - Set `carry_q`=(`sub_i` ? 1 : `cin_i`) and `idx`=0.
  - Operands are sampled only at the handshake. Later changes on `a_i`/`b_i` have no effect.
- **RUN:** each cycle, drive the adder with `a_q[4*idx +: 4]`, `b_q[4*idx +: 4]` and `carry_q`.
  - Register the adder's Sum into `sum_q[4*idx +: 4]`.
  - Set `carry_q` to the adder's Cout.
  - Increment `idx`.
  - When `idx`==NIBBLES−1, go to DONE. `cout_o` takes the final Cout.
  - The `idx` counter never wraps past NIBBLES−1.
- **DONE:** `rsp_valid_o`=1.
  - `sum_o`, `cout_o` and `ovf_o` are held stable until `rsp_ready_i` is sampled high.
  - `req_ready_o`=0. A `req_valid_i` in this state is ignored, not queued.

Overflow rule: `ovf_o` = (`a_q`[MSB] == `b_q`[MSB]) && (`sum_q`[MSB] != `a_q`[MSB]), where `b_q` is the post-inversion operand.

Arithmetic: the result is modulo 2^WIDTH.

## Timing

- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Reset values: state=IDLE, `rsp_valid_o`=0, `sum_o`=0, `cout_o`=0, `ovf_o`=0, `busy_o`=0.
- `req_ready_o`=0 while `rst_i` is high, and 1 from the first cycle after reset is released.
- Latency for a request accepted at edge k:
  - RUN occupies cycles k+1 to k+NIBBLES.
  - `rsp_valid_o` rises in cycle k+NIBBLES+1. For WIDTH=16 that is k+5.
- Response handshake at edge m puts the block in IDLE in cycle m+1, with `req_ready_o`=1 and `rsp_valid_o`=0.
- Minimum spacing between accepted requests is NIBBLES+2 cycles.
- Reset in the middle of an operation, in RUN or DONE, aborts it. The block returns to reset values on the next cycle and emits no partial response.
- Reset has priority over any handshake in the same cycle.

## Structure

- Package `serial_adder_pkg`:
  - `state_t` enum {IDLE, RUN, DONE}.
  - `NIBBLE_W`=4.
- Sub-module: exactly one instance of the existing `ripple_carry_adder`, fed by the nibble-slice mux. No other adders are inferred.

## Test plan

All scenarios use WIDTH=16.

1. Add `a`=0x1234, `b`=0x4321, `cin`=0, `sub`=0 → `sum`=0x5555, `cout`=0, `ovf`=0, with `rsp_valid_o` at handshake+5.
2. Add 0xFFFF + 0x0001, `cin`=0 → `sum`=0x0000, `cout`=1, `ovf`=0. This checks the carry chain through all four steps.
3. Add 0x7FFF + 0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1. Subtract 0x8000 − 0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
4. Subtract 0x0005 − 0x0007 with `cin_i`=0 (ignored) → `sum`=0xFFFE, `cout`=0, `ovf`=0.
5. Hold `rsp_ready_i` low for 10 cycles in DONE while toggling `req_valid_i` and the operands:
   - outputs stay stable, `req_ready_o`=0, and no new request is accepted;
   - after `rsp_ready_i` goes high, `req_ready_o`=1 on the next cycle.
6. Assert `rst_i` during the second RUN cycle → `busy_o`=0 and `rsp_valid_o`=0 on the next cycle; no response is emitted; `req_ready_o`=1 after reset is released.
